// File: rtl/sif_xa_arbiter_if.sv
// SIF XA bus bundle between the arbiter (master) and the SIF slave.
//   xa_wr_s / xa_rd_s : one-cycle write / read strobes from the master
//   xa_addr / xa_wdata: address and write data, valid with a strobe
//   xa_ready          : slave can accept a strobe this cycle
//   xa_rdata/xa_rd_vld: read data returned by the slave
interface sif_xa_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) ();
    logic              xa_wr_s;
    logic              xa_rd_s;
    logic [ADDR_W-1:0] xa_addr;
    logic [DATA_W-1:0] xa_wdata;
    logic              xa_ready;
    logic [DATA_W-1:0] xa_rdata;
    logic              xa_rd_vld;

    modport master (
        output xa_wr_s, xa_rd_s, xa_addr, xa_wdata,
        input  xa_ready, xa_rdata, xa_rd_vld
    );

    modport slave (
        input  xa_wr_s, xa_rd_s, xa_addr, xa_wdata,
        output xa_ready, xa_rdata, xa_rd_vld
    );
endinterface

// File: rtl/sif_xa_arbiter.sv
// Round-robin arbiter/sequencer sharing one SIF XA master port among N_REQ
// requesters. Each requester posts {wr,rd} = 10 (write), 01 (read) or
// 11 (illegal, answered with ack+err and no bus activity).
//   clk, rst_n           : clock, async active-low reset
//   req_wr/req_rd        : per-requester operation request (hold until ack)
//   req_addr/req_wdata   : packed per-requester address / write data
//   req_ack/req_err      : one-cycle completion / error pulse to the grantee
//   req_rdata            : last captured read data, valid with req_ack
//   gnt_id               : current / last granted requester
//   busy                 : high whenever the sequencer is not arbitrating
//   xa                   : SIF XA master port
//
// state   | meaning
// ARB     | idle, pick next pending requester round-robin
// ISSUE   | drive latched op; strobe fires the cycle xa_ready is high
// RD_WAIT | read issued, wait for xa_rd_vld or timeout
// RESP    | ack/err pulse to grantee, advance round-robin pointer
module sif_xa_arbiter #(
    parameter int N_REQ      = 4,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int RD_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_wr,
    input  logic [N_REQ-1:0]           req_rd,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr,
    input  logic [N_REQ*DATA_W-1:0]    req_wdata,
    output logic [N_REQ-1:0]           req_ack,
    output logic [N_REQ-1:0]           req_err,
    output logic [DATA_W-1:0]          req_rdata,
    output logic [$clog2(N_REQ)-1:0]   gnt_id,
    output logic                       busy,
    sif_xa_arbiter_if.master           xa
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int TMR_W = $clog2(RD_TIMEOUT);

    typedef enum logic [1:0] {ARB, ISSUE, RD_WAIT, RESP} state_t;

    state_t            state;
    logic [ID_W-1:0]   last_gnt;
    logic [TMR_W-1:0]  timer;
    logic              op_wr;
    logic              op_rd;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic [N_REQ-1:0]  pend;
    logic              found;
    logic [ID_W-1:0]   sel;
    logic [ID_W-1:0]   cand;
    int                idx;
    logic [N_REQ-1:0]  sel_oh;
    logic [N_REQ-1:0]  gnt_oh;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Search starts one past the last grant and wraps, which bounds the
    // wait of any pending requester to N_REQ grants.
    always_comb begin
        pend  = req_wr | req_rd;
        found = 1'b0;
        sel   = last_gnt;
        cand  = '0;
        idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = int'(last_gnt) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            cand = ID_W'(idx);
            if (!found && pend[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        sel_oh         = '0;
        sel_oh[sel]    = 1'b1;
        gnt_oh         = '0;
        gnt_oh[gnt_id] = 1'b1;
        sel_addr  = req_addr[int'(sel)*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[int'(sel)*DATA_W +: DATA_W];
    end

    // Strobes follow xa_ready combinationally so the single accepted cycle
    // is also the single strobe cycle.
    assign xa.xa_wr_s  = (state == ISSUE) & op_wr & xa.xa_ready;
    assign xa.xa_rd_s  = (state == ISSUE) & op_rd & xa.xa_ready;
    assign xa.xa_addr  = addr_q;
    assign xa.xa_wdata = wdata_q;
    assign busy        = (state != ARB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB;
            last_gnt  <= ID_W'(N_REQ - 1);
            gnt_id    <= '0;
            timer     <= '0;
            op_wr     <= 1'b0;
            op_rd     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            req_ack   <= '0;
            req_err   <= '0;
            req_rdata <= '0;
        end else begin
            req_ack <= '0;
            req_err <= '0;
            case (state)
                ARB: begin
                    if (found) begin
                        gnt_id  <= sel;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        op_wr   <= req_wr[sel];
                        op_rd   <= req_rd[sel];
                        if (req_wr[sel] && req_rd[sel]) begin
                            req_ack <= sel_oh;
                            req_err <= sel_oh;
                            state   <= RESP;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (xa.xa_ready) begin
                        if (op_wr) begin
                            req_ack <= gnt_oh;
                            state   <= RESP;
                        end else begin
                            timer <= TMR_W'(RD_TIMEOUT - 1);
                            state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (xa.xa_rd_vld) begin
                        req_rdata <= xa.xa_rdata;
                        req_ack   <= gnt_oh;
                        state     <= RESP;
                    end else if (timer == '0) begin
                        req_ack <= gnt_oh;
                        req_err <= gnt_oh;
                        state   <= RESP;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                RESP: begin
                    last_gnt <= gnt_id;
                    state    <= ARB;
                end
                default: state <= ARB;
            endcase
        end
    end
endmodule

// File: tb/tb_sif_xa_arbiter.sv
// Self-checking bench for sif_xa_arbiter: expected acks and bus strobes are
// queued when a request is posted and compared as the DUT produces them.
module tb_sif_xa_arbiter;
    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_wr, req_rd;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]  req_ack, req_err;
    logic [DW-1:0] req_rdata;
    logic [1:0]    gnt_id;
    logic          busy;

    sif_xa_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) xa_bus ();

    sif_xa_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_wr(req_wr), .req_rd(req_rd), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ack(req_ack), .req_err(req_err), .req_rdata(req_rdata),
        .gnt_id(gnt_id), .busy(busy), .xa(xa_bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int strobe_cyc = -1;
    int at, s, c0, prev;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int id; bit err; bit chk_rd; logic [DW-1:0] rdata; } ack_exp_t;
    typedef struct { bit wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; } stb_exp_t;
    ack_exp_t ack_q[$];
    stb_exp_t stb_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] oh(input int id);
        logic [N-1:0] r;
        r = '0;
        r[id] = 1'b1;
        return r;
    endfunction

    always @(negedge clk) begin : mon_ack
        ack_exp_t e;
        if (rst_n && (req_ack != '0)) begin
            if (ack_q.size() == 0) begin
                chk("ack_unexpected", 64'(req_ack), 64'd0);
            end else begin
                e = ack_q.pop_front();
                chk("ack_id", 64'(req_ack), 64'(oh(e.id)));
                chk("ack_err", 64'(req_err), 64'(e.err ? oh(e.id) : {N{1'b0}}));
                chk("gnt_id", 64'(gnt_id), 64'(e.id));
                if (e.chk_rd) chk("rdata", 64'(req_rdata), 64'(e.rdata));
            end
        end
    end

    always @(negedge clk) begin : mon_stb
        stb_exp_t x;
        if (rst_n && (xa_bus.xa_wr_s || xa_bus.xa_rd_s)) begin
            strobe_cyc = cyc;
            chk("one_strobe", 64'(xa_bus.xa_wr_s & xa_bus.xa_rd_s), 64'd0);
            if (stb_q.size() == 0) begin
                chk("stb_unexpected", 64'({xa_bus.xa_wr_s, xa_bus.xa_rd_s}), 64'd0);
            end else begin
                x = stb_q.pop_front();
                chk("stb_wr", 64'(xa_bus.xa_wr_s), 64'(x.wr));
                chk("stb_rd", 64'(xa_bus.xa_rd_s), 64'(!x.wr));
                chk("stb_addr", 64'(xa_bus.xa_addr), 64'(x.addr));
                if (x.wr) chk("stb_wdata", 64'(xa_bus.xa_wdata), 64'(x.wdata));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input bit wr, input bit rd,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[id*AW +: AW]  = a;
        req_wdata[id*DW +: DW] = d;
        req_wr[id] = wr;
        req_rd[id] = rd;
    endtask

    task automatic clr_req(input int id);
        req_wr[id] = 1'b0;
        req_rd[id] = 1'b0;
    endtask

    task automatic push_ack(input int id, input bit err, input bit chk_rd, input logic [DW-1:0] rd);
        ack_exp_t e;
        e.id = id; e.err = err; e.chk_rd = chk_rd; e.rdata = rd;
        ack_q.push_back(e);
    endtask

    task automatic push_stb(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        stb_exp_t x;
        x.wr = wr; x.addr = a; x.wdata = d;
        stb_q.push_back(x);
    endtask

    task automatic wait_ack(input int id, output int t);
        bit seen;
        seen = 1'b0;
        t = -1;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (req_ack[id]) begin
                seen = 1'b1;
                t = cyc;
            end
        end
        if (!seen) chk("ack_wait", 64'(req_ack[id]), 64'd1);
    endtask

    task automatic wait_stb(output int t);
        bit seen;
        seen = 1'b0;
        t = -1;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (xa_bus.xa_wr_s || xa_bus.xa_rd_s) begin
                seen = 1'b1;
                t = cyc;
            end
        end
        if (!seen) chk("stb_wait", 64'(xa_bus.xa_wr_s | xa_bus.xa_rd_s), 64'd1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

    initial begin
        req_wr = '0; req_rd = '0; req_addr = '0; req_wdata = '0;
        xa_bus.xa_ready = 1'b1; xa_bus.xa_rdata = '0; xa_bus.xa_rd_vld = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", 64'(req_ack), 64'd0);
        chk("rst_err", 64'(req_err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_gnt", 64'(gnt_id), 64'd0);
        chk("rst_strobes", 64'({xa_bus.xa_wr_s, xa_bus.xa_rd_s}), 64'd0);
        chk("rst_addr", 64'(xa_bus.xa_addr), 64'd0);
        chk("rst_rdata", 64'(req_rdata), 64'd0);
        tick();
        rst_n = 1'b1;
        tick(); tick();

        // single write from req0
        c0 = cyc;
        set_req(0, 1, 0, 8'h10, 32'hDEADBEEF);
        push_stb(1, 8'h10, 32'hDEADBEEF);
        push_ack(0, 0, 0, '0);
        wait_ack(0, at);
        chk("wr_stb_lat", 64'(strobe_cyc - c0), 64'd1);
        chk("wr_ack_lat", 64'(at - c0), 64'd2);
        tick(); clr_req(0); tick(); tick();

        // read from req2, data three cycles after the strobe
        set_req(2, 0, 1, 8'h44, '0);
        push_stb(0, 8'h44, '0);
        push_ack(2, 0, 1, 32'h12345678);
        wait_stb(s);
        repeat (3) @(posedge clk);
        #1;
        xa_bus.xa_rd_vld = 1'b1; xa_bus.xa_rdata = 32'h12345678;
        tick();
        xa_bus.xa_rd_vld = 1'b0; xa_bus.xa_rdata = '0;
        wait_ack(2, at);
        chk("rd_ack_lat", 64'(at - s), 64'd4);
        tick(); clr_req(2); tick(); tick();

        // read from req3 that never returns data
        set_req(3, 0, 1, 8'h7C, '0);
        push_stb(0, 8'h7C, '0);
        push_ack(3, 1, 1, 32'h12345678);
        wait_stb(s);
        wait_ack(3, at);
        chk("to_ack_lat", 64'(at - s), 64'(TO + 1));
        tick(); clr_req(3); tick(); tick();

        // all four requesters hold writes continuously
        c0 = cyc;
        for (int i = 0; i < N; i++) set_req(i, 1, 0, AW'(32'h20 + i), 32'hA0000000 + i);
        for (int k = 0; k < 5; k++) begin
            push_stb(1, AW'(32'h20 + (k % N)), 32'hA0000000 + (k % N));
            push_ack(k % N, 0, 0, '0);
        end
        prev = c0;
        for (int k = 0; k < 5; k++) begin
            wait_ack(k % N, at);
            chk("rr_spacing", 64'(at - prev), (k == 0) ? 64'd2 : 64'd3);
            prev = at;
        end
        tick(); req_wr = '0; tick(); tick();

        // illegal op from req1, then req0/req2 race resolves to req2
        c0 = cyc;
        set_req(1, 1, 1, 8'h31, '0);
        push_ack(1, 1, 0, '0);
        wait_ack(1, at);
        chk("ill_ack_lat", 64'(at - c0), 64'd1);
        tick(); clr_req(1); tick();
        set_req(0, 1, 0, 8'h40, 32'h00000040);
        set_req(2, 1, 0, 8'h42, 32'h00000042);
        push_stb(1, 8'h42, 32'h00000042); push_ack(2, 0, 0, '0);
        push_stb(1, 8'h40, 32'h00000040); push_ack(0, 0, 0, '0);
        wait_ack(2, at);
        tick(); clr_req(2);
        wait_ack(0, at);
        tick(); clr_req(0); tick(); tick();

        // slave not ready for five ISSUE cycles
        c0 = cyc;
        xa_bus.xa_ready = 1'b0;
        set_req(1, 1, 0, 8'h55, 32'h0BADF00D);
        push_stb(1, 8'h55, 32'h0BADF00D);
        push_ack(1, 0, 0, '0);
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 2) begin
                chk("issue_busy", 64'(busy), 64'd1);
                chk("issue_no_stb", 64'(xa_bus.xa_wr_s), 64'd0);
            end
        end
        xa_bus.xa_ready = 1'b1;
        wait_ack(1, at);
        chk("rdy_stb_lat", 64'(strobe_cyc - c0), 64'd6);
        chk("rdy_ack_lat", 64'(at - c0), 64'd7);
        tick(); clr_req(1); tick(); tick();

        // reset during RD_WAIT aborts the read
        set_req(0, 0, 1, 8'h66, '0);
        push_stb(0, 8'h66, '0);
        wait_stb(s);
        tick(); tick();
        rst_n = 1'b0;
        clr_req(0);
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_strobes", 64'({xa_bus.xa_wr_s, xa_bus.xa_rd_s}), 64'd0);
        chk("mid_rst_addr", 64'(xa_bus.xa_addr), 64'd0);
        chk("mid_rst_ack", 64'({req_ack, req_err}), 64'd0);
        chk("mid_rst_rdata", 64'(req_rdata), 64'd0);
        chk("mid_rst_gnt", 64'(gnt_id), 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        set_req(0, 1, 0, 8'h70, 32'h00000070);
        set_req(3, 1, 0, 8'h73, 32'h00000073);
        push_stb(1, 8'h70, 32'h00000070); push_ack(0, 0, 0, '0);
        push_stb(1, 8'h73, 32'h00000073); push_ack(3, 0, 0, '0);
        wait_ack(0, at);
        tick(); clr_req(0);
        wait_ack(3, at);
        tick(); clr_req(3);
        repeat (4) tick();

        chk("ack_q_empty", 64'(ack_q.size()), 64'd0);
        chk("stb_q_empty", 64'(stb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
